// File: rtl/div_pkg.sv
// Shared encodings for the iterative RV32M divider: op codes, FSM states and
// the divide-by-zero quotient pattern.
package div_pkg;

    localparam int DIV_XLEN = 32;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } div_state_e;

    localparam logic [DIV_XLEN-1:0] DIV_ZERO_Q = '1;

    // op[0]=0 selects the signed variants (DIV, REM); op[1]=1 returns the remainder
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/div_if.sv
// Execute-stage request/response bundle between the pipeline and div_unit.
interface div_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, dividend, divisor, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, op, dividend, divisor, flush,
        output busy, done, result
    );
endinterface

// File: rtl/div_step.sv
// One restoring shift-subtract step: shift the next dividend bit into the
// partial remainder and subtract the divisor if it fits.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic            quo_msb_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic            q_bit_o
);
    logic [XLEN:0] shifted;
    logic [XLEN:0] trial;

    // rem_i < divisor_i holds between steps, so the XLEN+1 bit MSB is a true sign
    assign shifted = {rem_i, quo_msb_i};
    assign trial   = shifted - {1'b0, divisor_i};
    assign q_bit_o = ~trial[XLEN];
    assign rem_o   = q_bit_o ? trial[XLEN-1:0] : shifted[XLEN-1:0];

endmodule

// File: rtl/div_unit.sv
// Iterative XLEN-bit divider for DIV/DIVU/REM/REMU: XLEN restoring steps plus
// a sign-fixup cycle. Define DIV_EARLY_OUT_EN to short-cut /0 and overflow.
module div_unit
    import div_pkg::*;
#(
    parameter int XLEN = DIV_XLEN
) (
    input  logic   clk,
    input  logic   rst_n,
    div_if.slave   bus
);
    localparam int CNT_W = $clog2(XLEN) + 1;

    div_state_e       state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic             neg_q_q, neg_q_d;
    logic             neg_r_q, neg_r_d;
    logic [XLEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]  quo_q, quo_d;
    logic [XLEN-1:0]  dvsr_q, dvsr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic             done_q, done_d;

    logic [XLEN-1:0]  step_rem;
    logic             step_q;
    logic             sgn, neg_a, neg_b;
    logic [XLEN-1:0]  abs_a, abs_b;
    logic [XLEN-1:0]  q_fix, r_fix;
`ifdef DIV_EARLY_OUT_EN
    logic             div_zero, sgn_ovf;
`endif

    div_step #(.XLEN(XLEN)) u_step (
        .rem_i     (rem_q),
        .quo_msb_i (quo_q[XLEN-1]),
        .divisor_i (dvsr_q),
        .rem_o     (step_rem),
        .q_bit_o   (step_q)
    );

    // -2^(XLEN-1) negates to itself, which is already the right unsigned magnitude
    assign sgn   = op_is_signed(bus.op);
    assign neg_a = sgn & bus.dividend[XLEN-1];
    assign neg_b = sgn & bus.divisor[XLEN-1];
    assign abs_a = neg_a ? -bus.dividend : bus.dividend;
    assign abs_b = neg_b ? -bus.divisor  : bus.divisor;

`ifdef DIV_EARLY_OUT_EN
    assign div_zero = (bus.divisor == '0);
    assign sgn_ovf  = sgn && (bus.dividend == {1'b1, {(XLEN-1){1'b0}}}) &&
                      (bus.divisor == '1);
`endif

    // A zero divisor yields all-ones naturally; negating it would break the RISC-V result
    assign q_fix = (neg_q_q && (dvsr_q != '0)) ? -quo_q : quo_q;
    assign r_fix = neg_r_q ? -rem_q : rem_q;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvsr_d   = dvsr_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        done_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.flush) begin
                    op_d    = bus.op;
                    neg_q_d = neg_a ^ neg_b;
                    neg_r_d = neg_a;
                    rem_d   = '0;
                    quo_d   = abs_a;
                    dvsr_d  = abs_b;
                    cnt_d   = CNT_W'(XLEN);
                    state_d = S_CALC;
`ifdef DIV_EARLY_OUT_EN
                    if (div_zero) begin
                        quo_d   = {XLEN{DIV_ZERO_Q[0]}};
                        rem_d   = abs_a;
                        state_d = S_FIX;
                    end else if (sgn_ovf) begin
                        quo_d   = {1'b1, {(XLEN-1){1'b0}}};
                        rem_d   = '0;
                        neg_q_d = 1'b0;
                        state_d = S_FIX;
                    end
`endif
                end
            end
            S_CALC: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    rem_d = step_rem;
                    quo_d = {quo_q[XLEN-2:0], step_q};
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!bus.flush) begin
                    result_d = op_q[1] ? r_fix : q_fix;
                    done_d   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvsr_q   <= dvsr_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy   = (state_q != S_IDLE);
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit: signed/unsigned ops, /0, overflow,
// busy-ignore, flush and asynchronous reset.
module tb_div_unit;
    import div_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    div_if #(.XLEN(32)) bus ();

    div_unit #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

`ifdef DIV_EARLY_OUT_EN
    localparam int SPECIAL_LAT = 1;
`else
    localparam int SPECIAL_LAT = 33;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // start on a negedge, count edges until done is seen #1 after a posedge
    task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] res, output int lat);
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.dividend = a; bus.divisor = b;
        @(posedge clk);
        #1 bus.start = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); lat++; #1;
        end while (!bus.done && lat < 100);
        check({tag, "_done"}, 32'(bus.done), 32'd1);
        res = bus.result;
    endtask

    task automatic vec(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        logic [31:0] r;
        int          l;
        do_op(tag, op, a, b, r, l);
        check(tag, r, exp);
        if (exp_lat > 0) check({tag, "_lat"}, 32'(l), 32'(exp_lat));
    endtask

    initial begin
        logic [31:0] r;
        int          l;
        int          ndone;

        bus.start = 1'b0; bus.op = OP_DIVU; bus.dividend = '0; bus.divisor = '0; bus.flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_result", bus.result, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        vec("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
        @(posedge clk) #1 check("done_pulse", 32'(bus.done), 32'd0);
        vec("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 33);
        vec("div_m7_2",   OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        vec("rem_m7_2",   OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0);
        vec("rem_7_m2",   OP_REM,  32'd7, 32'hFFFF_FFFE, 32'd1, 0);
        vec("div_7_m2",   OP_DIV,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 0);
        vec("divu_5_0",   OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, SPECIAL_LAT);
        vec("rem_5_0",    OP_REM,  32'd5, 32'd0, 32'd5, SPECIAL_LAT);
        vec("div_m5_0",   OP_DIV,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, SPECIAL_LAT);
        vec("rem_m5_0",   OP_REM,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 0);
        vec("div_ovf",    OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPECIAL_LAT);
        vec("rem_ovf",    OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);
        vec("divu_big",   OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);

        // start while busy must be ignored
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_DIVU; bus.dividend = 32'd100; bus.divisor = 32'd7;
        @(posedge clk);
        #1 bus.start = 1'b0;
        check("busy_after_start", 32'(bus.busy), 32'd1);
        l = 0;
        do begin
            @(posedge clk); l++; #1;
            if (l == 4) begin bus.start = 1'b1; bus.dividend = 32'd9; bus.divisor = 32'd3; end
            if (l == 5) bus.start = 1'b0;
        end while (!bus.done && l < 100);
        check("ign_done", 32'(bus.done), 32'd1);
        check("ign_result", bus.result, 32'd14);
        check("ign_lat", 32'(l), 32'd33);

        // flush mid-CALC
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_DIVU; bus.dividend = 32'd9; bus.divisor = 32'd3;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk) bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        check("flush_busy", 32'(bus.busy), 32'd0);
        ndone = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done) ndone++;
        end
        check("flush_nodone", 32'(ndone), 32'd0);
        check("flush_result", bus.result, 32'd14);
        vec("divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd3, 33);

        // flush beats a simultaneous start in IDLE
        @(negedge clk);
        bus.start = 1'b1; bus.flush = 1'b1; bus.op = OP_DIVU; bus.dividend = 32'd8; bus.divisor = 32'd2;
        @(posedge clk);
        #1 begin bus.start = 1'b0; bus.flush = 1'b0; end
        check("flush_start_busy", 32'(bus.busy), 32'd0);

        // asynchronous reset mid-CALC
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_DIVU; bus.dividend = 32'd100; bus.divisor = 32'd7;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_done", 32'(bus.done), 32'd0);
        check("arst_result", bus.result, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        do_op("divu_1_1", OP_DIVU, 32'd1, 32'd1, r, l);
        check("divu_1_1", r, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
